alu_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 25 ++
 rtl/seq_muldiv.sv | 68 ++++++
 rtl/alu_seq.sv | 159 +++++++++++++++
 tb/tb_alu_seq.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the sequential ALU.
package alu_pkg;

    localparam logic [1:0] MODE_ARITH = 2'b00;
    localparam logic [1:0] MODE_LOGIC = 2'b01;
    localparam logic [1:0] MODE_SHIFT = 2'b10;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b1000;

    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b1000;

    localparam logic [3:0] OP_SLL = 4'b0001;
    localparam logic [3:0] OP_SRL = 4'b0010;
    localparam logic [3:0] OP_SRA = 4'b0100;
    localparam logic [3:0] OP_ROL = 4'b1000;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned shift-add multiplier and restoring divider.
// res is the accumulator after the current step; done marks the last step.
module seq_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] res
);
    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opd;
    logic [CW-1:0]      cnt;
    logic               busy;
    logic               div_q;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;

    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                   + (acc[0] ? {1'b0, opd} : '0);
    assign rem_sh  = acc[2*WIDTH-1:WIDTH-1];
    assign diff    = rem_sh - {1'b0, opd};

    always_comb begin
        res = acc;
        if (div_q) begin
            if (diff[WIDTH])
                res = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
                res = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            res = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    assign done = busy && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            opd   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            div_q <= 1'b0;
        end else if (start) begin
            // multiplier sits in the low half; dividend is shifted out of it
            acc   <= div ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
            opd   <= div ? b : a;
            cnt   <= CW'(WIDTH - 1);
            busy  <= 1'b1;
            div_q <= div;
        end else if (busy) begin
            acc <= res;
            if (cnt == '0)
                busy <= 1'b0;
            else
                cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle arith/logic/shift plus iterative mul/div,
// with registered result and flags held until accepted.
module alu_seq
    import alu_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         alu_mode,
    input  logic [3:0]         opcode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               c,
    output logic               z,
    output logic               eq,
    output logic               gt,
    output logic               za,
    output logic               zb,
    output logic               dbz,
    output logic               illegal
);
    state_e state_q, state_d;

    logic               accept;
    logic               is_md;
    logic               md_done;
    logic [2*WIDTH-1:0] md_res;
    logic [2*WIDTH-1:0] sc_res;
    logic               sc_c;
    logic               sc_dbz;
    logic               sc_ill;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     dif;
    logic [SHW-1:0]     amt;
    logic [2*WIDTH-1:0] rot;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;

    assign sum = {1'b0, a} + {1'b0, b};
    assign dif = {1'b0, a} - {1'b0, b};
    assign amt = b[SHW-1:0];
    assign rot = {a, a} << amt;

    always_comb begin
        sc_res = '0;
        sc_c   = 1'b0;
        sc_dbz = 1'b0;
        sc_ill = 1'b0;
        is_md  = 1'b0;
        case (alu_mode)
            MODE_ARITH: begin
                case (opcode)
                    OP_ADD: begin
                        sc_res[WIDTH-1:0] = sum[WIDTH-1:0];
                        sc_c              = sum[WIDTH];
                    end
                    OP_SUB: begin
                        sc_res[WIDTH-1:0] = dif[WIDTH-1:0];
                        sc_c              = dif[WIDTH];
                    end
                    OP_MUL: is_md = 1'b1;
                    OP_DIV: begin
                        if (b == '0) begin
                            sc_res = {a, {WIDTH{1'b1}}};
                            sc_dbz = 1'b1;
                        end else begin
                            is_md = 1'b1;
                        end
                    end
                    default: sc_ill = 1'b1;
                endcase
            end
            MODE_LOGIC: begin
                case (opcode)
                    OP_AND:  sc_res[WIDTH-1:0] = a & b;
                    OP_OR:   sc_res[WIDTH-1:0] = a | b;
                    OP_XOR:  sc_res[WIDTH-1:0] = a ^ b;
                    OP_NOT:  sc_res[WIDTH-1:0] = ~a;
                    default: sc_ill = 1'b1;
                endcase
            end
            MODE_SHIFT: begin
                case (opcode)
                    OP_SLL:  sc_res[WIDTH-1:0] = a << amt;
                    OP_SRL:  sc_res[WIDTH-1:0] = a >> amt;
                    OP_SRA:  sc_res[WIDTH-1:0] = $signed(a) >>> amt;
                    OP_ROL:  sc_res[WIDTH-1:0] = rot[2*WIDTH-1:WIDTH];
                    default: sc_ill = 1'b1;
                endcase
            end
            default: sc_ill = 1'b1;
        endcase
    end

    seq_muldiv #(.WIDTH(WIDTH)) u_md (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept && is_md),
        .div   (opcode == OP_DIV),
        .a     (a),
        .b     (b),
        .done  (md_done),
        .res   (md_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = is_md ? BUSY : DONE;
            BUSY:    if (md_done) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result  <= '0;
            c       <= 1'b0;
            z       <= 1'b0;
            eq      <= 1'b0;
            gt      <= 1'b0;
            za      <= 1'b0;
            zb      <= 1'b0;
            dbz     <= 1'b0;
            illegal <= 1'b0;
        end else if (accept) begin
            result  <= sc_res;
            z       <= (sc_res == '0);
            c       <= sc_c;
            dbz     <= sc_dbz;
            illegal <= sc_ill;
            eq      <= (a == b);
            gt      <= (a > b);
            za      <= (a == '0);
            zb      <= (b == '0);
        end else if (state_q == BUSY && md_done) begin
            result <= md_res;
            z      <= (md_res == '0);
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=16.
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_mode;
    logic [3:0]  opcode;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        c, z, eq, gt, za, zb, dbz, illegal;

    int total = 0;
    int bad   = 0;

    alu_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_mode  (alu_mode),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .c         (c),
        .z         (z),
        .eq        (eq),
        .gt        (gt),
        .za        (za),
        .zb        (zb),
        .dbz       (dbz),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Present one op, accept it, then scramble the inputs and count cycles
    // (accept edge counts as 1) until out_valid is seen.
    task automatic run_op(input logic [1:0] m, input logic [3:0] op,
                          input logic [15:0] av, input logic [15:0] bv,
                          output int lat);
        @(negedge clk);
        alu_mode = m;
        opcode   = op;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 16'hDEAD;
        b        = 16'h0000;
        opcode   = 4'b0000;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic ack();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_mode  = 2'b00;
        opcode    = 4'b0000;
        a         = '0;
        b         = '0;
        #12;
        total++;
        if ({out_valid, result, c, z, eq, gt, za, zb, dbz, illegal} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got ov=%b res=%h flags=%b%b%b%b%b%b%b%b",
                     out_valid, result, c, z, eq, gt, za, zb, dbz, illegal);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
    endtask

    task automatic test_add();
        int lat;
        run_op(MODE_ARITH, OP_ADD, 16'hFFFF, 16'h0001, lat);
        total++;
        if (result !== 32'h0 || c !== 1'b1 || z !== 1'b1 || lat != 1) begin
            bad++;
            $display("FAIL add got res=%h c=%b z=%b lat=%0d want 00000000 1 1 1",
                     result, c, z, lat);
        end
        ack();
    endtask

    task automatic test_sub();
        int lat;
        run_op(MODE_ARITH, OP_SUB, 16'h0003, 16'h0005, lat);
        total++;
        if (result !== 32'h0000_FFFE || c !== 1'b1 || z !== 1'b0 || lat != 1) begin
            bad++;
            $display("FAIL sub got res=%h c=%b z=%b lat=%0d want 0000fffe 1 0 1",
                     result, c, z, lat);
        end
        ack();
    endtask

    task automatic test_mul();
        int lat;
        run_op(MODE_ARITH, OP_MUL, 16'h1234, 16'h5678, lat);
        total++;
        if (result !== 32'h0626_0060 || c !== 1'b0 || lat != 17) begin
            bad++;
            $display("FAIL mul got res=%h c=%b lat=%0d want 06260060 0 17",
                     result, c, lat);
        end
        ack();
    endtask

    task automatic test_div();
        int lat;
        run_op(MODE_ARITH, OP_DIV, 16'd100, 16'd7, lat);
        total++;
        if (result !== 32'h0002_000E || dbz !== 1'b0 || lat != 17) begin
            bad++;
            $display("FAIL div got res=%h dbz=%b lat=%0d want 0002000e 0 17",
                     result, dbz, lat);
        end
        ack();
        run_op(MODE_ARITH, OP_DIV, 16'd5, 16'd0, lat);
        total++;
        if (result !== 32'h0005_FFFF || dbz !== 1'b1 || zb !== 1'b1 || lat != 1) begin
            bad++;
            $display("FAIL div_zero got res=%h dbz=%b zb=%b lat=%0d want 0005ffff 1 1 1",
                     result, dbz, zb, lat);
        end
        ack();
    endtask

    task automatic test_shift_logic();
        int lat;
        run_op(MODE_SHIFT, OP_SRA, 16'h8001, 16'h0011, lat);
        total++;
        if (result !== 32'h0000_C000 || c !== 1'b0 || gt !== 1'b1) begin
            bad++;
            $display("FAIL sra got res=%h c=%b gt=%b want 0000c000 0 1", result, c, gt);
        end
        ack();
        run_op(MODE_SHIFT, OP_ROL, 16'h8001, 16'h0011, lat);
        total++;
        if (result !== 32'h0000_0003) begin
            bad++;
            $display("FAIL rol got=%h want=00000003", result);
        end
        ack();
        run_op(MODE_SHIFT, OP_SLL, 16'h8001, 16'h0004, lat);
        total++;
        if (result !== 32'h0000_0010) begin
            bad++;
            $display("FAIL sll got=%h want=00000010", result);
        end
        ack();
        run_op(MODE_LOGIC, OP_NOT, 16'h00FF, 16'h1234, lat);
        total++;
        if (result !== 32'h0000_FF00 || lat != 1) begin
            bad++;
            $display("FAIL not got res=%h lat=%0d want 0000ff00 1", result, lat);
        end
        ack();
        run_op(MODE_LOGIC, OP_XOR, 16'hF0F0, 16'h0FF0, lat);
        total++;
        if (result !== 32'h0000_FF00 || gt !== 1'b1 || eq !== 1'b0) begin
            bad++;
            $display("FAIL xor got res=%h gt=%b eq=%b want 0000ff00 1 0", result, gt, eq);
        end
        ack();
    endtask

    task automatic test_zero_flags();
        int lat;
        run_op(MODE_LOGIC, OP_AND, 16'h0000, 16'h0000, lat);
        total++;
        if ({eq, za, zb, gt, z} !== 5'b11101 || result !== 32'h0) begin
            bad++;
            $display("FAIL zero_flags got eq/za/zb/gt/z=%b res=%h want 11101 00000000",
                     {eq, za, zb, gt, z}, result);
        end
        ack();
    endtask

    task automatic test_hold_busy();
        int n;
        int errs;
        @(negedge clk);
        alu_mode = MODE_ARITH;
        opcode   = OP_MUL;
        a        = 16'd3;
        b        = 16'd5;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        alu_mode = MODE_LOGIC;
        opcode   = OP_OR;
        a        = 16'hFFFF;
        b        = 16'hFFFF;
        errs     = 0;
        n        = 1;
        while (!out_valid && n < 100) begin
            if (in_ready !== 1'b0) errs++;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        total++;
        if (errs != 0 || n != 17 || result !== 32'd15) begin
            bad++;
            $display("FAIL busy_no_accept got errs=%0d lat=%0d res=%h want 0 17 0000000f",
                     errs, n, result);
        end
        errs = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (result !== 32'd15 || out_valid !== 1'b1 || in_ready !== 1'b0
                || c !== 1'b0 || z !== 1'b0 || gt !== 1'b0) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL hold_stable got %0d bad cycles want 0", errs);
        end
        ack();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL release got in_ready=%b out_valid=%b want 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_div();
        int lat;
        int errs;
        @(negedge clk);
        alu_mode = MODE_ARITH;
        opcode   = OP_DIV;
        a        = 16'd100;
        b        = 16'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, result, c, z, eq, gt, za, zb, dbz, illegal} !== '0) begin
            bad++;
            $display("FAIL reset_mid_div got ov=%b res=%h gt=%b want all 0",
                     out_valid, result, gt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        errs  = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL aborted_no_output got %0d bad cycles want 0", errs);
        end
        run_op(MODE_ARITH, OP_ADD, 16'd2, 16'd2, lat);
        total++;
        if (result !== 32'h0000_0004 || lat != 1) begin
            bad++;
            $display("FAIL add_after_reset got res=%h lat=%0d want 00000004 1", result, lat);
        end
        ack();
    endtask

    task automatic test_illegal();
        int lat;
        run_op(2'b11, 4'b0001, 16'h1234, 16'h1234, lat);
        total++;
        if (illegal !== 1'b1 || result !== 32'h0 || z !== 1'b1 || eq !== 1'b1
            || lat != 1) begin
            bad++;
            $display("FAIL illegal_mode got ill=%b res=%h z=%b eq=%b lat=%0d want 1 0 1 1 1",
                     illegal, result, z, eq, lat);
        end
        ack();
        run_op(MODE_ARITH, 4'b0011, 16'h0007, 16'h0002, lat);
        total++;
        if (illegal !== 1'b1 || result !== 32'h0 || z !== 1'b1 || gt !== 1'b1
            || lat != 1) begin
            bad++;
            $display("FAIL illegal_op got ill=%b res=%h z=%b gt=%b lat=%0d want 1 0 1 1 1",
                     illegal, result, z, gt, lat);
        end
        ack();
        run_op(MODE_ARITH, OP_ADD, 16'd1, 16'd1, lat);
        total++;
        if (illegal !== 1'b0 || result !== 32'd2) begin
            bad++;
            $display("FAIL illegal_clear got ill=%b res=%h want 0 00000002", illegal, result);
        end
        ack();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_div();
        test_shift_logic();
        test_zero_flags();
        test_hold_busy();
        test_reset_mid_div();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
